scoreboard_regfile: RTL and testbench
=====================================

# scoreboard_regfile

Parametrised integer register file with an integrated per-register pending-write scoreboard. It provides NRD combinational read ports and NWR write-back ports, with a hardwired-zero register 0. Each register has a saturating counter of outstanding writes, so decode can issue several writes to the same destination. It sits between decode/dispatch, which reads sources and allocates destinations, and the execute/write-back stages, which retire results.

## Interface
Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers (power of two, ≥2).
- NRD, 2, read ports.
- NWR, 1, write-back ports.
- MAX_PEND, 3, maximum outstanding writes per register (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_valid  in  NRD  per-port read request.
- rd_addr  in  NRD×log2(NREGS)  read addresses.
- rd_data  out  NRD×XLEN  read data (combinational).
- rd_ready  out  1  high when every valid read port's register is not busy.
- alloc_valid  in  1  reserve a destination register.
- alloc_addr  in  log2(NREGS)  destination to reserve.
- alloc_ready  out  1  reservation can be accepted this cycle.
- wb_valid  in  NWR  write-back strobes.
- wb_addr  in  NWR×log2(NREGS)  write-back addresses.
- wb_data  in  NWR×XLEN  write-back data.
- flush  in  1  discard all pending reservations.
- busy_vec  out  NREGS  per-register busy flags (pending count ≠ 0).

## Operation
- Storage: NREGS×XLEN flops. Register 0 always reads 0. Writes to it are dropped, and it is never busy.
- Read: rd_data[i] = register[rd_addr[i]] regardless of rd_valid.
- rd_ready = AND over ports i with rd_valid[i] of !busy(rd_addr[i]). It is 1 when no port is valid.
- Allocation:
  - alloc_ready = 0 when pend[alloc_addr] == MAX_PEND; otherwise 1.
  - Accepted when alloc_valid && alloc_ready; then pend[alloc_addr] increments.
  - An allocation to register 0 is accepted and has no effect.
- Write-back:
  - Each valid port writes its data and decrements the pending count of its address.
  - Several ports writing the same address in one cycle: the highest port index wins the data, and the count decreases by the number of hitting ports.
  - Decrement saturates at 0; a stray write-back never underflows.
- Simultaneous events on one register: next pend = clamp(pend + alloc_hit − wb_hits, 0, MAX_PEND).
- Flush: all pending counts go to 0 next cycle. Same-cycle write-backs still write data, and same-cycle allocations are discarded. Register contents are preserved.
- Reset: all registers = 0 and all counts = 0, so rd_data = 0, rd_ready = 1, alloc_ready = 1 and busy_vec = 0.

## Timing
- Read data and rd_ready are combinational from addresses and current state; there is no read latency.
- A write-back is visible on rd_data the cycle after wb_valid (without bypass).
- An accepted allocation makes busy visible the next cycle.
- A write-back that brings the count to 0 clears busy the next cycle (without bypass).
- alloc_ready depends only on alloc_addr and state, not on alloc_valid.
- Reset asserted mid-operation clears state immediately and asynchronously; in-flight write-backs are lost.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Same-cycle forwarding: a read port whose address matches a valid write-back port (non-zero address) returns that wb_data, highest port index wins.
  - A register whose current count is 1 and that receives a write-back this cycle counts as not busy for rd_ready.
  - alloc_ready also counts same-cycle write-backs to its address: it is 1 when pend − wb_hits < MAX_PEND.
- REGFILE_BYPASS_EN undefined: no forwarding, and all effects are visible one cycle later as stated in Timing.

## Structure
- Shared package regfile_pkg:
  - defaults for XLEN and NREGS;
  - the address-width localparam computed via $clog2;
  - a pend_t typedef sized $clog2(MAX_PEND+1).
- Sub-module pend_counter: one per register, with inputs inc, dec_count, flush and an async reset; outputs count, busy and full. Instantiated NREGS−1 times via generate. Register 0 has no counter.
- Storage, read muxes and the optional bypass stay in scoreboard_regfile.

## Test plan
- Reset, then read x5 and x0 on both ports -> rd_data = 0, rd_ready = 1, alloc_ready = 1, busy_vec = 0.
- Allocate x3, then read x3 next cycle -> rd_ready = 0. Write-back x3 = 0xDEADBEEF -> next cycle rd_data = 0xDEADBEEF and rd_ready = 1. With bypass, rd_ready = 1 and data is returned in the write-back cycle.
- Allocate x7 three times (MAX_PEND = 3) -> alloc_ready = 0 on the fourth request. One write-back -> count 2 and alloc_ready = 1.
- Allocation and write-back to x4 in the same cycle with count 1 -> count stays 1 and x4 is still busy.
- NWR = 2, both ports write x9 (0x11, 0x22) with count 2 -> x9 = 0x22 and count 0. Write-back to x0 = 0xFF -> x0 still reads 0.
- Allocate x1, x2, x3, then flush together with an allocation of x6 -> busy_vec = 0 next cycle. A later write-back to x2 -> count stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and types for scoreboard_regfile
package regfile_pkg;
  localparam int XLEN_DEF     = 32;
  localparam int NREGS_DEF    = 32;
  localparam int ADDR_W       = $clog2(NREGS_DEF);
  localparam int MAX_PEND_DEF = 3;
  localparam int PEND_W       = $clog2(MAX_PEND_DEF + 1);

  typedef logic [PEND_W-1:0] pend_t;
endpackage

// File: rtl/pend_counter.sv
// rtl/pend_counter.sv - saturating outstanding-write counter for one register
module pend_counter
  import regfile_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int DW       = 1,
  localparam int CW      = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic [DW-1:0] dec_count,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          full
);

  int            sum;
  logic [CW-1:0] count_nxt;

  // Signed sum so stray write-backs clamp at zero instead of wrapping.
  always_comb begin
    sum = int'(count) + int'(inc) - int'(dec_count);
    if (flush || sum < 0) begin
      count_nxt = '0;
    end else if (sum > MAX_PEND) begin
      count_nxt = CW'(MAX_PEND);
    end else begin
      count_nxt = CW'(sum);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign busy = (count != '0);
  assign full = (count == CW'(MAX_PEND));

endmodule

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - register file with pending-write scoreboard; REGFILE_BYPASS_EN adds same-cycle forwarding
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int MAX_PEND = MAX_PEND_DEF,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NRD-1:0]            rd_valid,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data,
  output logic                      rd_ready,
  input  logic                      alloc_valid,
  input  logic [AW-1:0]             alloc_addr,
  output logic                      alloc_ready,
  input  logic [NWR-1:0]            wb_valid,
  input  logic [NWR-1:0][AW-1:0]    wb_addr,
  input  logic [NWR-1:0][XLEN-1:0]  wb_data,
  input  logic                      flush,
  output logic [NREGS-1:0]          busy_vec
);

  localparam int CW = $clog2(MAX_PEND + 1);
  localparam int DW = $clog2(NWR + 1);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0]  regs [NREGS];
  logic [DW-1:0]    hits [NREGS];
  logic [CW-1:0]    cnt  [NREGS];
  logic [NREGS-1:0] busy_w;
  logic [NREGS-1:0] full_w;
  logic             alloc_fire;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      hits[r] = '0;
      for (int w = 0; w < NWR; w++) begin
        if (wb_valid[w] && wb_addr[w] == AW'(r)) hits[r] = hits[r] + DW'(1);
      end
    end
  end

  assign alloc_ready = !full_w[alloc_addr] ||
                       (BYPASS && (int'(cnt[alloc_addr]) - int'(hits[alloc_addr]) < MAX_PEND));
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign cnt[0]    = '0;
  assign busy_w[0] = 1'b0;
  assign full_w[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_pend
    pend_counter #(.MAX_PEND(MAX_PEND), .DW(DW)) u_pend (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (alloc_fire && alloc_addr == AW'(r)),
      .dec_count (hits[r]),
      .flush     (flush),
      .count     (cnt[r]),
      .busy      (busy_w[r]),
      .full      (full_w[r])
    );
  end

  assign busy_vec = busy_w;

  // Ascending port order makes the highest write-back port win on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wb_valid[w] && wb_addr[w] != '0) regs[wb_addr[w]] <= wb_data[w];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data[i] = (rd_addr[i] == '0) ? '0 : regs[rd_addr[i]];
      if (BYPASS) begin
        for (int w = 0; w < NWR; w++) begin
          if (wb_valid[w] && wb_addr[w] != '0 && wb_addr[w] == rd_addr[i]) rd_data[i] = wb_data[w];
        end
      end
    end
  end

  // With forwarding, the last outstanding write retiring now releases the register.
  always_comb begin
    rd_ready = 1'b1;
    for (int i = 0; i < NRD; i++) begin
      if (rd_valid[i] && busy_w[rd_addr[i]] &&
          !(BYPASS && cnt[rd_addr[i]] == CW'(1) && hits[rd_addr[i]] != '0)) begin
        rd_ready = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - directed self-checking bench for scoreboard_regfile
module tb_scoreboard_regfile;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, MAX_PEND = 3, AW = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NRD-1:0]           rd_valid;
  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic                     rd_ready;
  logic                     alloc_valid;
  logic [AW-1:0]            alloc_addr;
  logic                     alloc_ready;
  logic [NWR-1:0]           wb_valid;
  logic [NWR-1:0][AW-1:0]   wb_addr;
  logic [NWR-1:0][XLEN-1:0] wb_data;
  logic                     flush;
  logic [NREGS-1:0]         busy_vec;

  int pass_cnt = 0;
  int total_cnt = 0;

  scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .MAX_PEND(MAX_PEND)) dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .alloc_ready(alloc_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    wb_valid    = '0;
    flush       = 1'b0;
  endtask

  task automatic do_alloc(input logic [AW-1:0] a);
    alloc_valid = 1'b1;
    alloc_addr  = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_valid = 2'b11; rd_addr[0] = 5'd5; rd_addr[1] = 5'd0;
    alloc_addr = 5'd5; wb_addr = '0; wb_data = '0; idle();
    step(); step();
    rst_n = 1'b1;
    #1;
    total_cnt++; if (rd_data[0] !== 32'h0) $display("FAIL reset_rd0 got %h want 0", rd_data[0]); else pass_cnt++;
    total_cnt++; if (rd_data[1] !== 32'h0) $display("FAIL reset_rd1 got %h want 0", rd_data[1]); else pass_cnt++;
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL reset_rd_ready got %b want 1", rd_ready); else pass_cnt++;
    total_cnt++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); else pass_cnt++;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL reset_busy got %h want 0", busy_vec); else pass_cnt++;
    rd_valid = '0;
  endtask

  task automatic test_alloc_wb();
    do_alloc(5'd3);
    rd_valid = 2'b01; rd_addr[0] = 5'd3;
    #1;
    total_cnt++; if (rd_ready !== 1'b0) $display("FAIL alloc_busy_rd_ready got %b want 0", rd_ready); else pass_cnt++;
    wb_valid = 2'b01; wb_addr[0] = 5'd3; wb_data[0] = 32'hDEADBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL wb_cycle_rd_ready got %b want 1", rd_ready); else pass_cnt++;
    total_cnt++; if (rd_data[0] !== 32'hDEADBEEF) $display("FAIL wb_cycle_fwd got %h want deadbeef", rd_data[0]); else pass_cnt++;
`else
    total_cnt++; if (rd_ready !== 1'b0) $display("FAIL wb_cycle_rd_ready got %b want 0", rd_ready); else pass_cnt++;
    total_cnt++; if (rd_data[0] !== 32'h0) $display("FAIL wb_cycle_data got %h want 0", rd_data[0]); else pass_cnt++;
`endif
    step(); idle(); #1;
    total_cnt++; if (rd_data[0] !== 32'hDEADBEEF) $display("FAIL wb_data_x3 got %h want deadbeef", rd_data[0]); else pass_cnt++;
    total_cnt++; if (rd_ready !== 1'b1) $display("FAIL wb_rd_ready got %b want 1", rd_ready); else pass_cnt++;
    rd_valid = '0;
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      alloc_addr = 5'd7; #1;
      total_cnt++; if (alloc_ready !== 1'b1) $display("FAIL sat_ready_%0d got %b want 1", k, alloc_ready); else pass_cnt++;
      do_alloc(5'd7);
    end
    alloc_valid = 1'b1; alloc_addr = 5'd7; #1;
    total_cnt++; if (alloc_ready !== 1'b0) $display("FAIL sat_full got %b want 0", alloc_ready); else pass_cnt++;
    step(); idle();
    alloc_addr = 5'd7; wb_valid = 2'b01; wb_addr[0] = 5'd7; wb_data[0] = 32'h77; #1;
`ifdef REGFILE_BYPASS_EN
    total_cnt++; if (alloc_ready !== 1'b1) $display("FAIL sat_wb_cycle got %b want 1", alloc_ready); else pass_cnt++;
`else
    total_cnt++; if (alloc_ready !== 1'b0) $display("FAIL sat_wb_cycle got %b want 0", alloc_ready); else pass_cnt++;
`endif
    step(); idle(); #1;
    total_cnt++; if (alloc_ready !== 1'b1) $display("FAIL sat_after_wb got %b want 1", alloc_ready); else pass_cnt++;
    total_cnt++; if (busy_vec[7] !== 1'b1) $display("FAIL sat_busy7 got %b want 1", busy_vec[7]); else pass_cnt++;
    wb_valid = 2'b11; wb_addr[0] = 5'd7; wb_addr[1] = 5'd7;
    step(); idle(); #1;
    total_cnt++; if (busy_vec[7] !== 1'b0) $display("FAIL sat_drain got %b want 0", busy_vec[7]); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    do_alloc(5'd4);
    alloc_valid = 1'b1; alloc_addr = 5'd4;
    wb_valid = 2'b01; wb_addr[0] = 5'd4; wb_data[0] = 32'h44;
    step(); idle(); #1;
    total_cnt++; if (busy_vec[4] !== 1'b1) $display("FAIL same_cycle_busy got %b want 1", busy_vec[4]); else pass_cnt++;
    wb_valid = 2'b01; wb_addr[0] = 5'd4; wb_data[0] = 32'h45;
    step(); idle(); #1;
    total_cnt++; if (busy_vec[4] !== 1'b0) $display("FAIL same_cycle_count1 got %b want 0", busy_vec[4]); else pass_cnt++;
    rd_addr[1] = 5'd4; #1;
    total_cnt++; if (rd_data[1] !== 32'h45) $display("FAIL same_cycle_data got %h want 45", rd_data[1]); else pass_cnt++;
  endtask

  task automatic test_dual_wb();
    do_alloc(5'd9);
    do_alloc(5'd9);
    wb_valid = 2'b11; wb_addr[0] = 5'd9; wb_addr[1] = 5'd9;
    wb_data[0] = 32'h11; wb_data[1] = 32'h22;
    step(); idle();
    rd_addr[0] = 5'd9; #1;
    total_cnt++; if (rd_data[0] !== 32'h22) $display("FAIL dual_wb_data got %h want 22", rd_data[0]); else pass_cnt++;
    total_cnt++; if (busy_vec[9] !== 1'b0) $display("FAIL dual_wb_count got %b want 0", busy_vec[9]); else pass_cnt++;
    wb_valid = 2'b10; wb_addr[1] = 5'd0; wb_data[1] = 32'hFF;
    rd_addr[0] = 5'd0;
    step(); idle(); #1;
    total_cnt++; if (rd_data[0] !== 32'h0) $display("FAIL x0_write got %h want 0", rd_data[0]); else pass_cnt++;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL x0_busy got %h want 0", busy_vec); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_alloc(5'd1);
    do_alloc(5'd2);
    do_alloc(5'd3);
    total_cnt++; if (busy_vec !== 32'h0000_000E) $display("FAIL flush_pre got %h want 0000000e", busy_vec); else pass_cnt++;
    flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd6;
    step(); idle(); #1;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL flush_busy got %h want 0", busy_vec); else pass_cnt++;
    wb_valid = 2'b01; wb_addr[0] = 5'd2; wb_data[0] = 32'h55;
    step(); idle();
    rd_addr[0] = 5'd2; #1;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL stray_wb_busy got %h want 0", busy_vec); else pass_cnt++;
    total_cnt++; if (rd_data[0] !== 32'h55) $display("FAIL stray_wb_data got %h want 55", rd_data[0]); else pass_cnt++;
    do_alloc(5'd2);
    wb_valid = 2'b01; wb_addr[0] = 5'd2;
    step(); idle(); #1;
    total_cnt++; if (busy_vec[2] !== 1'b0) $display("FAIL no_underflow got %b want 0", busy_vec[2]); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_alloc(5'd5);
    total_cnt++; if (busy_vec[5] !== 1'b1) $display("FAIL pre_rst_busy got %b want 1", busy_vec[5]); else pass_cnt++;
    rd_addr[0] = 5'd3;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (busy_vec !== 32'h0) $display("FAIL async_rst_busy got %h want 0", busy_vec); else pass_cnt++;
    total_cnt++; if (rd_data[0] !== 32'h0) $display("FAIL async_rst_data got %h want 0", rd_data[0]); else pass_cnt++;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alloc_wb();
    test_saturate();
    test_same_cycle();
    test_dual_wb();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
